// File: rtl/xor_bram_sched_pkg.sv
// Shared types and helpers for the XOR BRAM port scheduler.
// The record widths below are fixed by these package constants; the
// scheduler's parameters default to the same values and must agree with them.
package xor_bram_sched_pkg;

  localparam int SCHED_WIDTH      = 32;
  localparam int SCHED_DEPTH      = 1024;
  localparam int SCHED_AW         = $clog2(SCHED_DEPTH);
  localparam int SCHED_PORTS      = 2;
  localparam int SCHED_NUM_REQ    = 4;
  localparam int SCHED_RD_LATENCY = 2;
  localparam int ID_W             = (SCHED_NUM_REQ > 1) ? $clog2(SCHED_NUM_REQ) : 1;

  // One in-flight read on a lane: who issued it.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } lane_tag_t;

  // One write granted in the previous cycle; reads to this address must wait.
  typedef struct packed {
    logic                valid;
    logic [SCHED_AW-1:0] addr;
  } wr_rec_t;

  // Round-robin successor of the last granted requester.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] last_id,
                                               input int              num_req);
    if (int'(last_id) >= num_req - 1) begin
      return '0;
    end
    return last_id + ID_W'(1);
  endfunction

endpackage

// File: rtl/rr_lane_allocator.sv
// Combinational round-robin lane allocator.
// Scans requesters starting at rr_ptr and hands out memory lanes in scan order,
// skipping writes that collide with a write already granted this cycle and reads
// that hit an address written in the previous cycle (the memory has not committed it yet).
module rr_lane_allocator
  import xor_bram_sched_pkg::*;
#(
  parameter int PORTS   = SCHED_PORTS,
  parameter int NUM_REQ = SCHED_NUM_REQ,
  parameter int AW      = SCHED_AW
) (
  input  logic [ID_W-1:0]               rr_ptr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0][AW-1:0]    req_addr,
  input  logic [PORTS-1:0]              last_wr_valid,
  input  logic [PORTS-1:0][AW-1:0]      last_wr_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [PORTS-1:0][ID_W-1:0]    lane_sel,
  output logic [PORTS-1:0]              lane_used
);

  // Scan in round-robin order, filling lanes with hazard-free requests.
  always_comb begin
    logic [PORTS-1:0]         gw_valid;
    logic [PORTS-1:0][AW-1:0] gw_addr;
    int                       n_used;
    int                       scan;
    logic [ID_W-1:0]          idx;
    logic                     blocked;

    req_ready = '0;
    lane_sel  = '0;
    lane_used = '0;
    gw_valid  = '0;
    gw_addr   = '0;
    n_used    = 0;
    scan      = 0;
    idx       = '0;
    blocked   = 1'b0;

    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      idx     = ID_W'(scan);
      blocked = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
        if (req_we[idx]) begin
          if (gw_valid[p] && (gw_addr[p] == req_addr[idx])) begin
            blocked = 1'b1;
          end
        end else if (last_wr_valid[p] && (last_wr_addr[p] == req_addr[idx])) begin
          blocked = 1'b1;
        end
      end
      if (req_valid[idx] && !blocked && (n_used < PORTS)) begin
        req_ready[idx] = 1'b1;
        for (int p = 0; p < PORTS; p++) begin
          if (p == n_used) begin
            lane_sel[p]  = idx;
            lane_used[p] = 1'b1;
            gw_valid[p]  = req_we[idx];
            gw_addr[p]   = req_addr[idx];
          end
        end
        n_used = n_used + 1;
      end
    end
  end

endmodule

// File: rtl/xor_bram_port_scheduler.sv
// Shares one pipelined XOR BRAM among NUM_REQ requesters.
// Grants up to PORTS requests per cycle round-robin, drives one memory lane per
// grant, and routes read data back to the issuing requester after the fixed
// memory latency. Reads landing in the write-commit shadow are held off one cycle.
module xor_bram_port_scheduler
  import xor_bram_sched_pkg::*;
#(
  parameter  int WIDTH      = SCHED_WIDTH,
  parameter  int DEPTH      = SCHED_DEPTH,
  parameter  int PORTS      = SCHED_PORTS,
  parameter  int NUM_REQ    = SCHED_NUM_REQ,
  parameter  int RD_LATENCY = SCHED_RD_LATENCY,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0][AW-1:0]      req_addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [NUM_REQ-1:0][WIDTH-1:0]   resp_rdata,
  output logic [PORTS-1:0][AW-1:0]        mem_addr,
  output logic [PORTS-1:0][WIDTH-1:0]     mem_d,
  output logic [PORTS-1:0]                mem_en,
  input  logic [PORTS-1:0][WIDTH-1:0]     mem_q
);

  logic [ID_W-1:0]            rr_ptr;
  wr_rec_t                    last_wr  [PORTS];
  lane_tag_t                  tag_pipe [PORTS][RD_LATENCY];

  logic [PORTS-1:0]           last_wr_valid;
  logic [PORTS-1:0][AW-1:0]   last_wr_addr;
  logic [PORTS-1:0][ID_W-1:0] lane_sel;
  logic [PORTS-1:0]           lane_used;
  logic [PORTS-1:0]           lane_we;
  logic [ID_W-1:0]            last_grant;
  logic                       any_grant;

  rr_lane_allocator #(
    .PORTS   (PORTS),
    .NUM_REQ (NUM_REQ),
    .AW      (AW)
  ) u_alloc (
    .rr_ptr        (rr_ptr),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .last_wr_valid (last_wr_valid),
    .last_wr_addr  (last_wr_addr),
    .req_ready     (req_ready),
    .lane_sel      (lane_sel),
    .lane_used     (lane_used)
  );

  // Flatten the last-write table for the allocator's hazard check.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      last_wr_valid[p] = last_wr[p].valid;
      last_wr_addr[p]  = last_wr[p].addr;
    end
  end

  // Lane muxes: granted lanes carry their requester, idle lanes drive zeros.
  always_comb begin
    mem_addr = '0;
    mem_d    = '0;
    lane_we  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (lane_used[p]) begin
        mem_addr[p] = req_addr[lane_sel[p]];
        lane_we[p]  = req_we[lane_sel[p]];
        if (req_we[lane_sel[p]]) begin
          mem_d[p] = req_wdata[lane_sel[p]];
        end
      end
    end
    mem_en = lane_we;
  end

  // The highest used lane holds the last requester in scan order.
  always_comb begin
    any_grant  = |lane_used;
    last_grant = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (lane_used[p]) begin
        last_grant = lane_sel[p];
      end
    end
  end

  // Round-robin pointer advances past the last granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= rr_next(last_grant, NUM_REQ);
    end
  end

  // Remember this cycle's write addresses for next cycle's read hazard check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PORTS; p++) begin
        last_wr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        last_wr[p].valid <= lane_we[p];
        last_wr[p].addr  <= mem_addr[p];
      end
    end
  end

  // Per-lane tag shift register aligned with the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PORTS; p++) begin
        for (int s = 0; s < RD_LATENCY; s++) begin
          tag_pipe[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        tag_pipe[p][0].valid <= lane_used[p] & ~lane_we[p];
        tag_pipe[p][0].id    <= lane_sel[p];
        for (int s = 1; s < RD_LATENCY; s++) begin
          tag_pipe[p][s] <= tag_pipe[p][s-1];
        end
      end
    end
  end

  // Register returning read data into the issuing requester's response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      for (int p = 0; p < PORTS; p++) begin
        if (tag_pipe[p][RD_LATENCY-1].valid) begin
          resp_valid[tag_pipe[p][RD_LATENCY-1].id] <= 1'b1;
          resp_rdata[tag_pipe[p][RD_LATENCY-1].id] <= mem_q[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_bram_port_scheduler.sv
// Bench for xor_bram_port_scheduler with a behavioural pipelined XOR BRAM:
// reads return data RD_LATENCY cycles after issue, writes commit one cycle
// after issue, and a same-cycle read sees the pre-write value.
module tb_xor_bram_port_scheduler;

  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int AW = 10;
  localparam int P  = 2;
  localparam int N  = 4;
  localparam int L  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_we;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][W-1:0] req_wdata;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        resp_valid;
  logic [N-1:0][W-1:0] resp_rdata;
  logic [P-1:0][AW-1:0] mem_addr;
  logic [P-1:0][W-1:0] mem_d;
  logic [P-1:0]        mem_en;
  logic [P-1:0][W-1:0] mem_q;

  xor_bram_port_scheduler #(
    .WIDTH(W), .DEPTH(D), .PORTS(P), .NUM_REQ(N), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_en(mem_en), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_f(input int i);
    return 32'hC0DE0000 + 32'(i * 7);
  endfunction

  // memory stand-in
  logic [W-1:0]         mem_arr [D];
  bit                   mem_init;
  logic [P-1:0]         pw_en;
  logic [P-1:0][AW-1:0] pw_addr;
  logic [P-1:0][W-1:0]  pw_d;
  logic [P-1:0][W-1:0]  st1, st2;
  assign mem_q = st2;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < D; i++) mem_arr[i] <= init_f(i);
      pw_en    <= '0;
      mem_init <= 1'b1;
    end else begin
      for (int p = 0; p < P; p++) begin
        if (pw_en[p]) mem_arr[pw_addr[p]] <= pw_d[p];
        st1[p] <= mem_arr[mem_addr[p]];
        st2[p] <= st1[p];
      end
      pw_en   <= mem_en;
      pw_addr <= mem_addr;
      pw_d    <= mem_d;
    end
  end

  // reference model state
  typedef struct {
    int          due;
    int          id;
    logic [W-1:0] data;
  } exp_t;

  exp_t            expq[$];
  logic [AW-1:0]   lw_addr[$];
  logic [W-1:0]    gold [D];
  int              m_rr = 0;
  int              cyc = 0;
  logic [N-1:0]    m_ready = '0;
  int              n_chk = 0;
  int              n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: evaluate the model on the current inputs at the falling edge,
  // compare every DUT output, then advance the model and return just after the rising edge.
  task automatic cycle();
    logic [N-1:0]         er;
    logic [P-1:0]         een;
    logic [P-1:0][AW-1:0] eaddr;
    logic [P-1:0][W-1:0]  ed;
    logic [N-1:0]         ev;
    logic [N-1:0][W-1:0]  erd;
    logic [AW-1:0]        cw_a[$];
    logic [W-1:0]         cw_d[$];
    int                   rd_id[$];
    exp_t                 keep[$];
    int                   used;
    int                   last;
    int                   i;
    bit                   blocked;

    @(negedge clk);
    if (!rst_n) begin
      m_rr = 0;
      lw_addr.delete();
      expq.delete();
    end

    er = '0; een = '0; eaddr = '0; ed = '0; used = 0; last = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (req_valid[i] && used < P) begin
        blocked = 1'b0;
        if (req_we[i]) begin
          foreach (cw_a[j]) if (cw_a[j] == req_addr[i]) blocked = 1'b1;
        end else begin
          foreach (lw_addr[j]) if (lw_addr[j] == req_addr[i]) blocked = 1'b1;
        end
        if (!blocked) begin
          er[i]       = 1'b1;
          eaddr[used] = req_addr[i];
          een[used]   = req_we[i];
          if (req_we[i]) begin
            ed[used] = req_wdata[i];
            cw_a.push_back(req_addr[i]);
            cw_d.push_back(req_wdata[i]);
          end else begin
            rd_id.push_back(i);
          end
          used++;
          last = i;
        end
      end
    end

    ev = '0; erd = '0;
    foreach (expq[j]) begin
      if (expq[j].due == cyc) begin
        ev[expq[j].id]  = 1'b1;
        erd[expq[j].id] = expq[j].data;
      end else if (expq[j].due > cyc) begin
        keep.push_back(expq[j]);
      end
    end
    expq = keep;

    chk("req_ready", 128'(req_ready), 128'(er));
    chk("ready_without_valid", 128'(req_ready & ~req_valid), 128'(0));
    chk("mem_en", 128'(mem_en), 128'(een));
    chk("mem_addr", 128'(mem_addr), 128'(eaddr));
    chk("mem_d", 128'(mem_d), 128'(ed));
    chk("resp_valid", 128'(resp_valid), 128'(ev));
    for (int r = 0; r < N; r++) begin
      if (ev[r]) chk("resp_rdata", 128'(resp_rdata[r]), 128'(erd[r]));
    end

    if (rst_n) begin
      foreach (rd_id[j]) begin
        exp_t e;
        e.due  = cyc + L + 1;
        e.id   = rd_id[j];
        e.data = gold[req_addr[rd_id[j]]];
        expq.push_back(e);
      end
      if (last >= 0) m_rr = (last + 1) % N;
      lw_addr = cw_a;
    end
    foreach (cw_a[j]) gold[cw_a[j]] = cw_d[j];
    m_ready = er;
    cyc++;

    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[r] = v;
    req_we[r]    = we;
    req_addr[r]  = a;
    req_wdata[r] = d;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    for (int i = 0; i < D; i++) gold[i] = init_f(i);
    rst_n     = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // reset with all requesters reading
    for (int r = 0; r < N; r++) set_req(r, 1'b1, 1'b0, AW'(10'h100 + r), '0);
    #1;
    chk("rst_ready", 128'(req_ready), 128'(4'b0011));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    cycle();
    cycle();
    chk("rst_ready_hold", 128'(req_ready), 128'(4'b0011));
    rst_n = 1'b1;

    // fairness: continuous reads from all four
    for (int k = 0; k < 8; k++) begin
      chk("fair_ready", 128'(req_ready), (k % 2 == 0) ? 128'(4'b0011) : 128'(4'b1100));
      if (k < 3) chk("fair_resp", 128'(resp_valid), 128'(0));
      else       chk("fair_resp", 128'(resp_valid), (k % 2 == 1) ? 128'(4'b0011) : 128'(4'b1100));
      if (k == 3) chk("fair_rdata0", 128'(resp_rdata[0]), 128'(32'hC0DE0700));
      cycle();
    end
    idle(4);

    // write/write collision on 0x10
    set_req(0, 1'b1, 1'b1, 10'h010, 32'h1111_0000);
    set_req(1, 1'b1, 1'b1, 10'h010, 32'h2222_0001);
    #1;
    chk("ww_first", 128'(req_ready), 128'(4'b0001));
    cycle();
    req_valid[0] = 1'b0;
    #1;
    chk("ww_second", 128'(req_ready), 128'(4'b0010));
    cycle();
    req_valid[1] = 1'b0;
    cycle();
    set_req(2, 1'b1, 1'b0, 10'h010, '0);
    #1;
    chk("ww_read_ready", 128'(req_ready), 128'(4'b0100));
    cycle();
    req_valid[2] = 1'b0;
    cycle();
    cycle();
    chk("ww_resp_valid", 128'(resp_valid), 128'(4'b0100));
    chk("ww_rdata", 128'(resp_rdata[2]), 128'(32'h2222_0001));

    // RAW window on 0x20
    set_req(0, 1'b1, 1'b1, 10'h020, 32'h0000_A5A5);
    #1;
    chk("raw_write", 128'(req_ready), 128'(4'b0001));
    cycle();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b0, 10'h020, '0);
    #1;
    chk("raw_blocked", 128'(req_ready), 128'(4'b0000));
    cycle();
    chk("raw_granted", 128'(req_ready), 128'(4'b0010));
    cycle();
    req_valid[1] = 1'b0;
    cycle();
    cycle();
    chk("raw_resp_valid", 128'(resp_valid), 128'(4'b0010));
    chk("raw_rdata", 128'(resp_rdata[1]), 128'(32'h0000_A5A5));

    // read-before-write on 0x30
    set_req(2, 1'b1, 1'b0, 10'h030, '0);
    set_req(3, 1'b1, 1'b1, 10'h030, 32'h0000_BEEF);
    #1;
    chk("rbw_ready", 128'(req_ready), 128'(4'b1100));
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    chk("rbw_resp_valid", 128'(resp_valid), 128'(4'b0100));
    chk("rbw_rdata", 128'(resp_rdata[2]), 128'(32'hC0DE0150));

    // random mixed traffic with one mid-run reset
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        rst_n     = 1'b0;
        req_valid = '0;
      end else if (c == 5003) begin
        rst_n = 1'b1;
      end
      if (rst_n) begin
        for (int r = 0; r < N; r++) begin
          if (!req_valid[r] || m_ready[r]) begin
            set_req(r, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
                    $urandom);
          end
        end
      end
      cycle();
    end
    idle(6);
    chk("drain_outstanding", 128'(expq.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
